// File: rtl/ddr2_user_port_master.sv
// ddr2_user_port_master: client-side initiator that runs the DDR2 controller user command handshake
module ddr2_user_port_master #(
  parameter int ROW_W = 13,
  parameter int COL_W = 10,
  parameter int LEN_W = 6
) (
  input  logic                   clk_int,
  input  logic                   sys_rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ROW_W+COL_W-1:0] req_addr,
  input  logic [1:0]             req_bank,
  input  logic [LEN_W-1:0]       req_len,
  output logic                   wr_data_req,
  input  logic [63:0]            wr_data,
  input  logic [7:0]             wr_mask,
  output logic                   rd_valid,
  output logic [63:0]            rd_data,
  output logic                   rd_last,
  output logic                   done,
  output logic                   init_done,
  output logic [3:0]             user_command_register,
  output logic [ROW_W+COL_W-1:0] user_input_address,
  output logic [1:0]             user_bank_address,
  output logic                   burst_done,
  output logic [63:0]            user_input_data,
  output logic [7:0]             user_data_mask,
  input  logic                   user_cmd_ack,
  input  logic                   user_data_valid,
  input  logic [63:0]            user_output_data,
  input  logic                   init_val,
  input  logic                   auto_ref_req,
  input  logic                   ar_done
);
  localparam int AW = ROW_W + COL_W;
  typedef enum logic [2:0] {
    S_INIT_CMD, S_INIT_WAIT, S_IDLE, S_CMD, S_XFER, S_BDONE, S_RD_DRAIN
  } state_t;
  state_t r_state, w_next;
  logic r_wr, r_bdc, r_init_done, r_rd_valid, r_rd_last;
  logic [3:0] r_cmd;
  logic [AW-1:0] r_addr;
  logic [1:0] r_bank;
  logic [LEN_W:0] r_two_len, r_cnt, r_rx_cnt;
  logic [63:0] r_wdata, r_rd_data;
  logic [7:0] r_wmask;
  logic [LEN_W-1:0] w_len;
  logic w_accept, w_ack_go, w_xfer_last, w_rx_all, w_rd_fin, w_capture, w_wr, w_wr_req, w_unused;
  assign req_ready   = (r_state == S_IDLE) & ~auto_ref_req;
  assign w_accept    = req_valid & req_ready;
  assign w_len       = (req_len == '0) ? LEN_W'(1) : req_len;
  assign w_ack_go    = (r_state == S_CMD) & user_cmd_ack;
  assign w_xfer_last = (r_state == S_XFER) & (r_cnt == r_two_len - 1'b1);
  assign w_rx_all    = r_rx_cnt == r_two_len;
  assign w_rd_fin    = r_rd_valid & r_rd_last;
  assign w_capture   = ~r_wr & user_data_valid & ~w_rx_all &
                       ((r_state == S_XFER) | (r_state == S_BDONE) | (r_state == S_RD_DRAIN));
  assign w_wr        = (r_state == S_IDLE) ? req_write : r_wr;
  assign w_wr_req    = r_wr & ((r_state == S_XFER) | w_ack_go);
  assign w_unused    = ar_done;
  assign wr_data_req           = w_wr_req;
  assign burst_done            = r_state == S_BDONE;
  assign done                  = ((r_state == S_BDONE) & r_bdc & (r_wr | w_rx_all)) |
                                 ((r_state == S_RD_DRAIN) & w_rd_fin);
  assign init_done             = r_init_done;
  assign user_command_register = r_cmd;
  assign user_input_address    = r_addr;
  assign user_bank_address     = r_bank;
  assign user_input_data       = r_wdata;
  assign user_data_mask        = r_wmask;
  assign rd_valid              = r_rd_valid;
  assign rd_data               = r_rd_data;
  assign rd_last               = r_rd_last;
  // state register
  always_ff @(posedge clk_int) begin
    if (sys_rst) r_state <= S_INIT_CMD;
    else r_state <= w_next;
  end
  // next-state: init handshake, then request/command/transfer/burst-end/drain loop
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT_CMD:  w_next = S_INIT_WAIT;
      S_INIT_WAIT: w_next = init_val ? S_IDLE : S_INIT_WAIT;
      S_IDLE:      w_next = w_accept ? S_CMD : S_IDLE;
      S_CMD:       w_next = user_cmd_ack ? S_XFER : S_CMD;
      S_XFER:      w_next = w_xfer_last ? S_BDONE : S_XFER;
      S_BDONE:     w_next = ~r_bdc ? S_BDONE : (r_wr | w_rx_all) ? S_IDLE : S_RD_DRAIN;
      S_RD_DRAIN:  w_next = w_rd_fin ? S_IDLE : S_RD_DRAIN;
      default:     w_next = S_INIT_CMD;
    endcase
  end
  // registered controller-side outputs, request latch, address stepping and read capture
  always_ff @(posedge clk_int) begin
    if (sys_rst) begin
      r_cmd       <= 4'b0000;
      r_init_done <= 1'b0;
      r_bdc       <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_data   <= '0;
      r_rx_cnt    <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_bank      <= '0;
      r_two_len   <= '0;
      r_cnt       <= '0;
    end else begin
      r_cmd       <= (r_state == S_INIT_CMD) ? 4'b0010 :
                     ((w_next == S_CMD) | (w_next == S_XFER)) ? (w_wr ? 4'b0100 : 4'b0110) : 4'b0000;
      r_init_done <= r_init_done | ((r_state == S_INIT_WAIT) & init_val);
      r_bdc       <= (r_state == S_BDONE) & ~r_bdc;
      r_rd_valid  <= w_capture;
      r_rd_last   <= w_capture & (r_rx_cnt == r_two_len - 1'b1);
      if (w_capture) begin
        r_rd_data <= user_output_data;
        r_rx_cnt  <= r_rx_cnt + 1'b1;
      end
      if (w_wr_req) begin
        r_wdata <= wr_data;
        r_wmask <= wr_mask;
      end
      if (w_accept) begin
        r_wr      <= req_write;
        r_addr    <= req_addr;
        r_bank    <= req_bank;
        r_two_len <= {w_len, 1'b0};
        r_cnt     <= '0;
        r_rx_cnt  <= '0;
      end else if (w_ack_go) begin
        r_cnt <= (LEN_W+1)'(1);
      end else if ((r_state == S_XFER) & ~w_xfer_last) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt[0]) r_addr <= {r_addr[AW-1:COL_W], r_addr[COL_W-1:0] + COL_W'(4)};
      end
    end
  end
endmodule

// File: tb/tb_ddr2_user_port_master.sv
// tb_ddr2_user_port_master: table-driven and randomized checks of the DDR2 user port master
module tb_ddr2_user_port_master;
  logic clk_int = 1'b0;
  always #5 clk_int = ~clk_int;
  logic sys_rst, req_valid, req_ready, req_write, wr_data_req, rd_valid, rd_last, done, init_done;
  logic burst_done, user_cmd_ack, user_data_valid, init_val, auto_ref_req, ar_done;
  logic [22:0] req_addr, user_input_address;
  logic [1:0] req_bank, user_bank_address;
  logic [5:0] req_len;
  logic [63:0] wr_data, rd_data, user_input_data, user_output_data;
  logic [7:0] wr_mask, user_data_mask;
  logic [3:0] user_command_register;
  int total = 0, bad = 0;
  typedef struct {
    logic wr; logic [22:0] addr; logic [1:0] bank; logic [5:0] len;
    int ack_dly; int rd_dly; int extra; int ref_cyc; logic [22:0] exp_last;
  } vec_t;
  vec_t vecs[6];
  ddr2_user_port_master dut (
    .clk_int(clk_int), .sys_rst(sys_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_bank(req_bank), .req_len(req_len),
    .wr_data_req(wr_data_req), .wr_data(wr_data), .wr_mask(wr_mask), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_last(rd_last), .done(done), .init_done(init_done),
    .user_command_register(user_command_register), .user_input_address(user_input_address),
    .user_bank_address(user_bank_address), .burst_done(burst_done),
    .user_input_data(user_input_data), .user_data_mask(user_data_mask),
    .user_cmd_ack(user_cmd_ack), .user_data_valid(user_data_valid),
    .user_output_data(user_output_data), .init_val(init_val), .auto_ref_req(auto_ref_req),
    .ar_done(ar_done)
  );
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask
  // one request: expected cycle timeline derived from the request parameters alone
  task automatic do_req(input vec_t v);
    int L, nb, a, bd1, rs, done_c, endc;
    logic [9:0] col;
    logic [3:0] op;
    logic [22:0] ea[$];
    logic [63:0] d[$];
    logic [63:0] r[$];
    logic [7:0] m[$];
    L = (v.len == 0) ? 1 : int'(v.len);
    nb = 2 * L;
    a = v.ack_dly;
    bd1 = a + nb;
    rs = bd1 + v.rd_dly;
    done_c = v.wr ? bd1 + 1 : rs + nb;
    endc = done_c + 2;
    op = v.wr ? 4'b0100 : 4'b0110;
    for (int u = 0; u < L; u++) begin
      col = v.addr[9:0] + 10'(4 * u);
      repeat (2) ea.push_back({v.addr[22:10], col});
    end
    for (int k = 0; k < nb; k++) begin
      d.push_back({$urandom, $urandom});
      m.push_back(8'($urandom));
    end
    for (int k = 0; k < nb + v.extra; k++) r.push_back({$urandom, $urandom});
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_bank = v.bank; req_len = v.len;
    auto_ref_req = v.ref_cyc > 0;
    for (int i = 0; i < v.ref_cyc; i++) begin
      @(negedge clk_int);
      chk("ref_blocks_ready", req_ready, 0);
      chk("ref_blocks_cmd", user_command_register, 0);
      @(posedge clk_int); #1;
    end
    auto_ref_req = 1'b0;
    @(negedge clk_int);
    chk("req_ready", req_ready, 1);
    @(posedge clk_int); #1;
    req_valid = 1'b0; req_addr = 23'($urandom); req_len = 6'($urandom);
    for (int c = 0; c <= endc; c++) begin
      user_cmd_ack = (c == a);
      user_data_valid = !v.wr && c >= rs && c < rs + nb + v.extra;
      if (user_data_valid) user_output_data = r[c - rs];
      else user_output_data = {$urandom, $urandom};
      if (v.wr && c >= a && c < bd1) begin
        wr_data = d[c - a]; wr_mask = m[c - a];
      end else begin
        wr_data = {$urandom, $urandom}; wr_mask = 8'($urandom);
      end
      auto_ref_req = (c < done_c) ? 1'($urandom) : 1'b0;
      @(negedge clk_int);
      chk("cmd", user_command_register, (c < bd1) ? op : 4'b0000);
      if (c < bd1) begin
        chk("addr", user_input_address, (c < a) ? v.addr : ea[c - a]);
        chk("bank", user_bank_address, v.bank);
      end
      if (c == bd1 - 1) chk("last_addr", user_input_address, v.exp_last);
      chk("wr_data_req", wr_data_req, v.wr && c >= a && c < bd1);
      chk("burst_done", burst_done, c == bd1 || c == bd1 + 1);
      chk("done", done, c == done_c);
      chk("req_ready_busy", req_ready, c > done_c);
      if (v.wr && c > a && c <= bd1) begin
        chk("wdata", user_input_data, d[c - a - 1]);
        chk("wmask", user_data_mask, m[c - a - 1]);
      end
      chk("rd_valid", rd_valid, !v.wr && c > rs && c <= rs + nb);
      chk("rd_last", rd_last, !v.wr && c == rs + nb);
      if (!v.wr && c > rs && c <= rs + nb) chk("rd_data", rd_data, r[c - rs - 1]);
      chk("init_held", init_done, 1);
      @(posedge clk_int); #1;
    end
    user_cmd_ack = 1'b0; user_data_valid = 1'b0; auto_ref_req = 1'b0;
  endtask
  initial begin
    vec_t rv;
    int L;
    vecs[0] = '{1'b1, 23'h000100, 2'd2, 6'd2, 3, 0, 0, 0, 23'h000104};
    vecs[1] = '{1'b0, 23'h000200, 2'd1, 6'd1, 2, 5, 0, 0, 23'h000200};
    vecs[2] = '{1'b1, 23'h0017FC, 2'd3, 6'd2, 1, 0, 0, 0, 23'h001400};
    vecs[3] = '{1'b0, 23'h000040, 2'd0, 6'd0, 0, 0, 2, 0, 23'h000040};
    vecs[4] = '{1'b0, 23'h0013F8, 2'd2, 6'd3, 4, 1, 1, 3, 23'h001000};
    vecs[5] = '{1'b1, 23'h7FFFF0, 2'd1, 6'd5, 2, 0, 0, 1, 23'h7FFC00};
    sys_rst = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_bank = 0; req_len = 0;
    wr_data = 0; wr_mask = 0; user_cmd_ack = 0; user_data_valid = 0; user_output_data = 0;
    init_val = 0; auto_ref_req = 0; ar_done = 0;
    repeat (3) @(posedge clk_int);
    #1 sys_rst = 1'b0;
    for (int c = 0; c < 22; c++) begin
      init_val = c >= 20;
      @(negedge clk_int);
      chk("init_cmd", user_command_register, (c == 1) ? 4'b0010 : 4'b0000);
      chk("init_done", init_done, c >= 21);
      chk("init_ready", req_ready, c >= 21);
      if (c == 0) begin
        chk("rst_addr", user_input_address, 0);
        chk("rst_bd", burst_done, 0);
        chk("rst_done", done, 0);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_wreq", wr_data_req, 0);
      end
      @(posedge clk_int); #1;
    end
    foreach (vecs[i]) do_req(vecs[i]);
    for (int n = 0; n < 20; n++) begin
      rv.wr = 1'($urandom);
      rv.addr = {13'($urandom), 8'($urandom), 2'b00};
      rv.bank = 2'($urandom);
      rv.len = 6'($urandom_range(0, 7));
      rv.ack_dly = $urandom_range(0, 5);
      rv.rd_dly = $urandom_range(0, 6);
      rv.extra = $urandom_range(0, 2);
      rv.ref_cyc = $urandom_range(0, 2);
      L = (rv.len == 0) ? 1 : int'(rv.len);
      rv.exp_last = {rv.addr[22:10], rv.addr[9:0] + 10'(4 * (L - 1))};
      do_req(rv);
    end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 23'h000200; req_bank = 2'd1; req_len = 6'd4;
    @(negedge clk_int);
    @(posedge clk_int); #1;
    req_valid = 1'b0; user_cmd_ack = 1'b1;
    @(posedge clk_int); #1;
    user_cmd_ack = 1'b0;
    @(posedge clk_int); #1;
    sys_rst = 1'b1;
    @(negedge clk_int);
    chk("mid_xfer_wreq", wr_data_req, 1);
    @(posedge clk_int); #1;
    sys_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_int);
      chk("rerun_cmd", user_command_register, (c == 1) ? 4'b0010 : 4'b0000);
      chk("rerun_done", done, 0);
      chk("rerun_bd", burst_done, 0);
      chk("rerun_wreq", wr_data_req, 0);
      chk("rerun_init_done", init_done, c >= 2);
      if (c == 0) begin
        chk("rerun_addr", user_input_address, 0);
        chk("rerun_bank", user_bank_address, 0);
        chk("rerun_wdata", user_input_data, 0);
        chk("rerun_ready", req_ready, 0);
      end
      @(posedge clk_int); #1;
    end
    do_req(vecs[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ddr2_user_port_master.md
Name: ddr2_user_port_master

Overview:
- Client-side initiator for the DDR2 controller's user command interface.
- Takes simple read/write burst requests from a datapath client and runs the full controller handshake: init command, command register, user_cmd_ack, address stepping, burst_done, write-data feed and read-data capture.
- Sits between switch datapath logic and the DDR2 controller top, in the controller's clk_int domain.

Parameters:
ROW_W, 13, row address bits
COL_W, 10, column address bits; controller address width is ROW_W+COL_W
LEN_W, 6, width of request length in address units (1 unit = one burst-of-4 = two 64-bit beats)

Ports:
clk_int  in  1  controller clock; all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&req_ready
req_write  in  1  1=write, 0=read
req_addr  in  ROW_W+COL_W  start address {row,col}; col[1:0] must be 0
req_bank  in  2  bank
req_len  in  LEN_W  number of address units; 0 treated as 1
wr_data_req  out  1  client must present wr_data/wr_mask this cycle
wr_data  in  64  write beat
wr_mask  in  8  write byte mask
rd_valid  out  1  read beat valid
rd_data  out  64  read beat
rd_last  out  1  final beat of read request
done  out  1  one-cycle pulse at request completion
init_done  out  1  controller initialised
user_command_register  out  4  0000 NOP, 0010 init, 0100 write, 0110 read
user_input_address  out  ROW_W+COL_W  controller address
user_bank_address  out  2  controller bank
burst_done  out  1  end-of-burst strobe
user_input_data  out  64  registered write data
user_data_mask  out  8  registered write mask
user_cmd_ack  in  1  controller command acknowledge
user_data_valid  in  1  controller read data valid
user_output_data  in  64  controller read data
init_val  in  1  controller init complete
auto_ref_req  in  1  controller refresh pending
ar_done  in  1  refresh complete (monitor only)

Behaviour:
- Reset: all outputs 0, command NOP, state INIT_CMD. Reset mid-operation aborts the transfer (no done) and re-runs init.
- INIT_CMD: drive command 0010 for exactly 1 cycle -> INIT_WAIT.
- INIT_WAIT: command NOP. Wait for init_val=1, then set init_done=1 (held until reset) -> IDLE.
- IDLE:
  - req_ready = ~auto_ref_req (registered-free, combinational from state).
  - On accept, latch write flag, addr, bank and len (len 0 -> 1); unit counter = 0 -> CMD.
- CMD:
  - Drive 0100/0110 with the latched address and bank.
  - Wait for user_cmd_ack=1 with no timeout; on first high cycle -> XFER.
- XFER:
  - Each address unit lasts 2 cycles with the address held. Address then increments by 4 in the column field only; the column wraps modulo 2^COL_W and row bits never change.
  - Command held for the whole phase.
  - Write: wr_data_req=1 every XFER cycle. Data sampled that cycle appears on user_input_data/user_data_mask the next cycle, so the first beat is on the bus 1 cycle after the ack-detect cycle.
  - After 2*len cycles -> BDONE.
- BDONE:
  - burst_done=1 and command=NOP for exactly 2 cycles; wr_data_req=0.
  - Write: done pulses in the 2nd BDONE cycle -> IDLE.
  - Read: -> RD_DRAIN (or directly done if all beats already received).
- Read capture (any state after CMD):
  - Each user_data_valid=1 cycle registers user_output_data to rd_data with rd_valid=1, 1-cycle latency.
  - A beat counter counts to 2*len. rd_last=1 with the final beat, and done pulses the same cycle -> IDLE.
  - Extra user_data_valid beyond 2*len, or while IDLE, is dropped (rd_valid stays 0).
- auto_ref_req is only consulted in IDLE; an in-flight burst always completes. Simultaneous req_valid and auto_ref_req rising in IDLE: request not accepted.
- done and rd_last never assert outside a request. init_done never drops except on reset.

Test Plan:
- Reset, init_val rises at cycle 20 -> command 0010 for 1 cycle at cycle 1, NOP after, init_done=1 at cycle 21, req_ready=1.
- Write addr 0x000100, bank 2, len 2; ack 3 cycles after command -> address 0x100 for 2 cycles then 0x104 for 2. wr_data_req high 4 cycles, data D0..D3 on user_input_data one cycle later. burst_done high 2 cycles, done in 2nd.
- Read len 1, controller returns 2 beats 5 cycles after burst_done -> rd_valid twice, rd_last on 2nd, done same cycle, then IDLE.
- auto_ref_req=1 while req_valid=1 -> req_ready=0, no command. Drop auto_ref_req -> accepted next cycle.
- Write starting at column 0x3FC, len 2 -> second address column 0x000 with row unchanged.
- sys_rst asserted mid-XFER -> next cycle all outputs 0, no done; init sequence repeats.
